// File: rtl/onchip_ram_arbiter.sv
// Two-master arbiter for a single-port on-chip RAM: one access per cycle, reads return 1 cycle later.
// Command accept is combinational (waitrequest low); owner bursts are bounded, m1 protected from starvation.
module onchip_ram_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 32,
  parameter int PRIO_MODE  = 0,
  parameter int BURST_MAX  = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [3:0] BURST_LIM  = 4'(BURST_MAX);
  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);
  localparam bit         PRIO       = (PRIO_MODE != 0);

  state_t     state_q, state_d;
  logic [3:0] burst_cnt_q, burst_cnt_d;
  logic [7:0] starve_cnt_q, starve_cnt_d;
  logic       rr_last_q, rr_last_d;
  logic       rd_vld_q, rd_vld_d;
  logic       rd_mst_q, rd_mst_d;

  logic req0, req1, gnt, gnt_sel, starved, burst_done, own_same, acc0, acc1, sel_wr;

  assign req0       = m0_read | m0_write;
  assign req1       = m1_read | m1_write;
  assign starved    = PRIO && req1 && (starve_cnt_q == STARVE_LIM);
  assign burst_done = (burst_cnt_q >= BURST_LIM);

  // In fixed-priority mode m0 is never preempted by the burst limit; only starvation hands m1 the port.
  always_comb begin
    gnt     = req0 | req1;
    gnt_sel = 1'b0;
    case (state_q)
      OWN0: begin
        if (starved)                                     gnt_sel = 1'b1;
        else if (req0 && (!req1 || PRIO || !burst_done)) gnt_sel = 1'b0;
        else                                             gnt_sel = req1;
      end
      OWN1: begin
        if (req1 && (!req0 || !burst_done)) gnt_sel = 1'b1;
        else                                gnt_sel = 1'b0;
      end
      default: begin
        if (req0 && req1) gnt_sel = PRIO ? starved : !rr_last_q;
        else              gnt_sel = req1;
      end
    endcase
  end

  assign acc0     = reset_n & gnt & !gnt_sel;
  assign acc1     = reset_n & gnt & gnt_sel;
  assign own_same = gnt_sel ? (state_q == OWN1) : (state_q == OWN0);
  assign sel_wr   = gnt_sel ? m1_write : m0_write;

  always_comb begin
    state_d      = gnt ? (gnt_sel ? OWN1 : OWN0) : IDLE;
    rr_last_d    = gnt ? gnt_sel : rr_last_q;
    burst_cnt_d  = 4'd0;
    if (gnt) begin
      if (!own_same)                burst_cnt_d = 4'd1;
      else if (!burst_done)         burst_cnt_d = burst_cnt_q + 4'd1;
      else                          burst_cnt_d = burst_cnt_q;
    end
    starve_cnt_d = 8'd0;
    if (PRIO && req1 && !acc1)
      starve_cnt_d = (starve_cnt_q < STARVE_LIM) ? starve_cnt_q + 8'd1 : starve_cnt_q;
    // A read+write collision is treated as a write: no read return is tagged.
    rd_vld_d     = gnt && !sel_wr;
    rd_mst_d     = gnt_sel;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      burst_cnt_q  <= 4'd0;
      starve_cnt_q <= 8'd0;
      rr_last_q    <= 1'b1;
      rd_vld_q     <= 1'b0;
      rd_mst_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      rr_last_q    <= rr_last_d;
      rd_vld_q     <= rd_vld_d;
      rd_mst_q     <= rd_mst_d;
    end
  end

  assign m0_waitrequest   = !acc0;
  assign m1_waitrequest   = !acc1;
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = rd_vld_q & !rd_mst_q;
  assign m1_readdatavalid = rd_vld_q & rd_mst_q;

  assign mem_address    = gnt_sel ? m1_address    : m0_address;
  assign mem_byteenable = gnt_sel ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = gnt_sel ? m1_writedata  : m0_writedata;
  assign mem_chipselect = reset_n & gnt;
  assign mem_write      = mem_chipselect & sel_wr;
  assign mem_clken      = 1'b1;

endmodule

// File: tb/tb_onchip_ram_arbiter.sv
// Drives a round-robin and a fixed-priority arbiter from shared masters, each with its own RAM.
module tb_onchip_ram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [10:0] m0_address, m1_address;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] m0_wd, m1_wd;

  logic [1:0]        m0_wait, m1_wait, m0_rdv, m1_rdv, cs, mwr, clken;
  logic [1:0][31:0]  m0_rd, m1_rd, mem_wd;
  logic [1:0][10:0]  mem_a;
  logic [1:0][3:0]   mem_be;

  int errors = 0;
  int checks = 0;

  logic [31:0] shadow [2][2048];
  logic [33:0] sbq [$];
  logic [31:0] last_rd [2][2];
  logic        acc_log0 [$];

  for (genvar g = 0; g < 2; g++) begin : inst
    logic [31:0] ram [2048];
    logic [31:0] q;
    onchip_ram_arbiter #(.ADDR_W(11), .DATA_W(32), .PRIO_MODE(g), .BURST_MAX(4), .STARVE_MAX(8)) dut (
      .clk(clk), .reset_n(reset_n),
      .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write), .m0_byteenable(m0_be),
      .m0_writedata(m0_wd), .m0_waitrequest(m0_wait[g]), .m0_readdata(m0_rd[g]),
      .m0_readdatavalid(m0_rdv[g]),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write), .m1_byteenable(m1_be),
      .m1_writedata(m1_wd), .m1_waitrequest(m1_wait[g]), .m1_readdata(m1_rd[g]),
      .m1_readdatavalid(m1_rdv[g]),
      .mem_address(mem_a[g]), .mem_byteenable(mem_be[g]), .mem_chipselect(cs[g]),
      .mem_write(mwr[g]), .mem_writedata(mem_wd[g]), .mem_clken(clken[g]), .mem_readdata(q)
    );
    always @(posedge clk) begin
      if (cs[g] && mwr[g])
        for (int b = 0; b < 4; b++)
          if (mem_be[g][b]) ram[mem_a[g]][8*b +: 8] <= mem_wd[g][8*b +: 8];
      q <= ram[mem_a[g]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: expected read data is queued at accept, compared on the following cycle.
  initial begin
    logic [1:0]  pend_v;
    logic        pend_m [2];
    logic [31:0] pend_d [2];
    logic [33:0] e;
    logic        m, w, acc;
    logic [10:0] a;
    logic [3:0]  be;
    logic [31:0] wd, rd;
    forever begin
      @(negedge clk);
      pend_v = 2'b00;
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        pend_v[e[33]] = 1'b1;
        pend_m[e[33]] = e[32];
        pend_d[e[33]] = e[31:0];
      end
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("i%0d_clken", i), 32'(clken[i]), 32'd1);
        if (!reset_n) begin
          chk($sformatf("i%0d_rst_rdv", i), 32'({m0_rdv[i], m1_rdv[i]}), 32'd0);
          chk($sformatf("i%0d_rst_wait", i), 32'({m0_wait[i], m1_wait[i]}), 32'd3);
          chk($sformatf("i%0d_rst_cs", i), 32'(cs[i]), 32'd0);
        end else begin
          chk($sformatf("i%0d_rdv0", i), 32'(m0_rdv[i]), 32'(pend_v[i] && !pend_m[i]));
          chk($sformatf("i%0d_rdv1", i), 32'(m1_rdv[i]), 32'(pend_v[i] && pend_m[i]));
          if (pend_v[i]) begin
            rd = pend_m[i] ? m1_rd[i] : m0_rd[i];
            chk($sformatf("i%0d_rdata", i), rd, pend_d[i]);
            last_rd[i][pend_m[i]] = rd;
          end
          chk($sformatf("i%0d_one_acc", i), 32'(m0_wait[i] | m1_wait[i]), 32'd1);
          acc = !m0_wait[i] || !m1_wait[i];
          chk($sformatf("i%0d_cs", i), 32'(cs[i]), 32'(acc));
          if (acc) begin
            m  = !m1_wait[i];
            if (i == 0) acc_log0.push_back(m);
            a  = m ? m1_address : m0_address;
            w  = m ? m1_write   : m0_write;
            be = m ? m1_be      : m0_be;
            wd = m ? m1_wd      : m0_wd;
            chk($sformatf("i%0d_addr", i), 32'(mem_a[i]), 32'(a));
            chk($sformatf("i%0d_mwr", i), 32'(mwr[i]), 32'(w));
            if (w) begin
              chk($sformatf("i%0d_wdata", i), mem_wd[i], wd);
              for (int b = 0; b < 4; b++)
                if (be[b]) shadow[i][a][8*b +: 8] = wd[8*b +: 8];
            end else begin
              sbq.push_back({1'(i), m, shadow[i][a]});
            end
          end
        end
      end
    end
  end

  task automatic do_cmd(input bit m, input bit wr, input logic [10:0] a, input logic [3:0] be,
                        input logic [31:0] d);
    int n;
    n = 0;
    if (m) begin
      m1_address = a; m1_write = wr; m1_read = !wr; m1_be = be; m1_wd = d;
    end else begin
      m0_address = a; m0_write = wr; m0_read = !wr; m0_be = be; m0_wd = d;
    end
    do begin
      @(negedge clk);
      n++;
    end while ((m ? m1_wait[0] : m0_wait[0]) && n < 20);
    chk("cmd_accept", 32'(m ? m1_wait[0] : m0_wait[0]), 32'd0);
    @(posedge clk); #1;
    if (m) begin m1_read = 1'b0; m1_write = 1'b0; end
    else   begin m0_read = 1'b0; m0_write = 1'b0; end
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int n;
    logic [23:0] gv, ev;
    reset_n = 1'b0;
    m0_address = 11'h010; m1_address = 11'h000;
    m0_read = 1'b1; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
    m0_be = 4'hF; m1_be = 4'hF; m0_wd = '0; m1_wd = '0;
    for (int i = 0; i < 2; i++) begin last_rd[i][0] = '0; last_rd[i][1] = '0; end

    // Reset with a request pending: nothing may be accepted.
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_wait0", 32'(m0_wait[i]), 32'd1);
      chk("reset_wait1", 32'(m1_wait[i]), 32'd1);
      chk("reset_cs", 32'(cs[i]), 32'd0);
      chk("reset_rdv", 32'(m0_rdv[i] | m1_rdv[i]), 32'd0);
    end
    @(posedge clk); #1;
    reset_n = 1'b1; m0_read = 1'b0;

    do_cmd(1'b0, 1'b1, 11'h010, 4'hF, 32'hDEADBEEF);
    do_cmd(1'b0, 1'b0, 11'h010, 4'hF, 32'h0);
    @(posedge clk); #1;
    chk("rd_deadbeef_i0", last_rd[0][0], 32'hDEADBEEF);
    chk("rd_deadbeef_i1", last_rd[1][0], 32'hDEADBEEF);

    do_cmd(1'b1, 1'b1, 11'h030, 4'hF, 32'h11223344);
    do_cmd(1'b1, 1'b1, 11'h030, 4'h2, 32'h0000AB00);
    do_cmd(1'b1, 1'b0, 11'h030, 4'hF, 32'h0);
    @(posedge clk); #1;
    chk("byte_merge_i0", last_rd[0][1], 32'h1122AB44);
    chk("byte_merge_i1", last_rd[1][1], 32'h1122AB44);

    // Read and write together: treated as a write.
    m0_address = 11'h040; m0_wd = 32'hCAFE0055; m0_be = 4'hF; m0_read = 1'b1; m0_write = 1'b1;
    @(negedge clk);
    chk("rw_accept", 32'(m0_wait[0]), 32'd0);
    @(posedge clk); #1;
    m0_read = 1'b0; m0_write = 1'b0;
    do_cmd(1'b0, 1'b0, 11'h040, 4'hF, 32'h0);
    @(posedge clk); #1;
    chk("rw_readback", last_rd[0][0], 32'hCAFE0055);

    // Both masters streaming reads.
    pulse_reset();
    m0_address = 11'h010; m1_address = 11'h030;
    acc_log0.delete();
    m0_read = 1'b1; m1_read = 1'b1;
    repeat (24) @(negedge clk);
    @(posedge clk); #1;
    m0_read = 1'b0; m1_read = 1'b0;
    chk("stream_count", 32'(acc_log0.size()), 32'd24);
    gv = '0;
    for (int k = 0; k < 24; k++) begin
      ev[k] = ((k / 4) % 2) == 1;
      if (k < acc_log0.size()) gv[k] = acc_log0[k];
    end
    chk("stream_order", 32'(gv), 32'(ev));

    // Fixed priority: m1 gets in on its 9th request cycle.
    pulse_reset();
    m0_read = 1'b1; m1_read = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m1_wait[1] && n < 30);
    chk("starve_cycle", 32'(n), 32'd9);
    @(posedge clk); #1;
    m1_read = 1'b0;
    @(negedge clk);
    chk("prio_back_to_m0", 32'(m0_wait[1]), 32'd0);
    @(posedge clk); #1;
    m0_read = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;

    // Reset right after an accepted read discards the return.
    do_cmd(1'b0, 1'b0, 11'h010, 4'hF, 32'h0);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_rdv_i0", 32'(m0_rdv[0]), 32'd0);
    chk("midrst_rdv_i1", 32'(m0_rdv[1]), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    m0_read = 1'b1; m1_read = 1'b1;
    @(negedge clk);
    chk("post_rst_rdv", 32'(m0_rdv[0] | m1_rdv[0]), 32'd0);
    chk("post_rst_grant", 32'({m0_wait[0], m1_wait[0]}), 32'b01);
    @(posedge clk); #1;
    m0_read = 1'b0; m1_read = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
